// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 13:1 mux scan sequencer.
package mux_scan_pkg;
  localparam int N_CH    = 13;
  localparam int SEL_W   = 4;
  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mux_next_sel.sv
// Priority finder: lowest enabled channel overall (first=1) or lowest enabled above cur.
module mux_next_sel #(
  parameter int N_CH  = mux_scan_pkg::N_CH,
  parameter int SEL_W = mux_scan_pkg::SEL_W
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);
  logic [N_CH-1:0] cand;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      assign cand[gi] = mask[gi] & (first | (SEL_W'(gi) > cur));
    end
  endgenerate

  // Walk downward so the lowest candidate is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux13_scan_ctrl.sv
// Start/busy/done scan sequencer driving the 13:1 mux select and snapshotting its output.
module mux13_scan_ctrl #(
  parameter int N_CH    = mux_scan_pkg::N_CH,
  parameter int SEL_W   = mux_scan_pkg::SEL_W,
  parameter int DWELL_W = mux_scan_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_CH-1:0]    en_mask,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done,
  output logic [N_CH-1:0]    sample
);
  import mux_scan_pkg::*;

  state_t             state_reg,  state_next;
  logic [SEL_W-1:0]   sel_reg,    sel_next;
  logic [DWELL_W-1:0] cnt_reg,    cnt_next;
  logic [DWELL_W-1:0] dwell_reg,  dwell_next;
  logic [N_CH-1:0]    mask_reg,   mask_next;
  logic [N_CH-1:0]    work_reg,   work_next;
  logic [N_CH-1:0]    sample_reg, sample_next;

  logic [SEL_W-1:0]   first_sel, step_sel;
  logic               first_found, step_found;

  // First lookup reads the live mask because it is being latched on the same edge.
  mux_next_sel #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
    .mask (en_mask),
    .cur  ('0),
    .first(1'b1),
    .nxt  (first_sel),
    .found(first_found)
  );

  mux_next_sel #(.N_CH(N_CH), .SEL_W(SEL_W)) u_step (
    .mask (mask_reg),
    .cur  (sel_reg),
    .first(1'b0),
    .nxt  (step_sel),
    .found(step_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      cnt_reg    <= '0;
      dwell_reg  <= '0;
      mask_reg   <= '0;
      work_reg   <= '0;
      sample_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      cnt_reg    <= cnt_next;
      dwell_reg  <= dwell_next;
      mask_reg   <= mask_next;
      work_reg   <= work_next;
      sample_reg <= sample_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    cnt_next    = cnt_reg;
    dwell_next  = dwell_reg;
    mask_next   = mask_reg;
    work_next   = work_reg;
    sample_next = sample_reg;

    // Shared by a fresh start and a continuous restart.
    if ((state_reg == ST_IDLE && start && !abort) ||
        (state_reg == ST_DONE && cont && !abort)) begin
      dwell_next = dwell;
      mask_next  = en_mask;
      cnt_next   = dwell;
      work_next  = '0;
      if (first_found) begin
        state_next = ST_SCAN;
        sel_next   = first_sel;
      end else begin
        state_next  = ST_DONE;
        sel_next    = '0;
        sample_next = '0;
      end
    end else begin
      case (state_reg)
        ST_SCAN: begin
          if (abort) begin
            state_next = ST_IDLE;
            sel_next   = '0;
          end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - DWELL_W'(1);
          end else begin
            work_next[sel_reg] = mux_out;
            if (step_found) begin
              sel_next = step_sel;
              cnt_next = dwell_reg;
            end else begin
              state_next  = ST_DONE;
              sample_next = work_next;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          sel_next   = '0;
        end
      endcase
    end
  end

  assign sel    = sel_reg;
  assign busy   = (state_reg == ST_SCAN);
  assign done   = (state_reg == ST_DONE) && !abort;
  assign sample = sample_reg;
endmodule

// File: doc/mux13_scan_ctrl.md
Name: mux13_scan_ctrl

Overview:
Sequencer for the 13:1 single-bit mux. It drives `sel` through an enabled subset of the 13 inputs and holds each channel for a programmable settle time. It captures the mux output per channel into a 13-bit snapshot word. It replaces free-running `sel` stepping with a start/busy/done handshake and supports one-shot or continuous scanning.

Parameters:
- N_CH, 13, number of mux inputs; the maximum legal channel index is N_CH-1.
- SEL_W, 4, width of `sel`; must satisfy 2**SEL_W >= N_CH.
- DWELL_W, 4, width of the settle-count input.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- abort  in  1  terminates the scan in progress; has priority over all other inputs except rst_n.
- cont  in  1  continuous mode; sampled at each scan end.
- dwell  in  DWELL_W  extra settle cycles per channel; latched at start.
- en_mask  in  N_CH  per-channel enable, bit i selects channel i; latched at start.
- mux_out  in  1  output of the 13:1 mux.
- sel  out  SEL_W  select driven to the mux.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse at scan completion.
- sample  out  N_CH  snapshot of the last completed scan; disabled bits read 0.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, sel=0, busy=0, done=0, sample=0, dwell counter=0, latched mask=0. Reset mid-scan discards the scan; no done pulse is issued.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN on start=1:
  - latch dwell and en_mask;
  - sel = lowest enabled index;
  - counter = dwell;
  - working register = 0.
- IDLE -> DONE on start=1 with en_mask=0; sample is then written to 0.
- SCAN, counter != 0: decrement the counter; sel holds.
- SCAN, counter == 0 (capture edge):
  - working[sel] <= mux_out;
  - if a higher enabled index exists, sel moves to the next enabled index and the counter reloads with the latched dwell;
  - otherwise go to DONE and write sample = final working value, including the bit captured at this edge.
- Each enabled channel occupies exactly dwell+1 cycles. A scan of k enabled channels keeps busy high for k*(dwell+1) cycles.
- DONE lasts one cycle with done=1 and busy=0. The next state is SCAN if cont=1, otherwise IDLE.
- Continuous restart from DONE re-latches dwell and en_mask at that edge, exactly as a start does.
- sample updates only at scan completion and is stable at all other times, including during the following scan.
- abort=1 in SCAN or DONE: go to IDLE, sel=0, no done pulse (a pending done is suppressed), sample unchanged.
- abort=1 in IDLE: no effect; start is ignored in the same cycle.
- start while in SCAN or DONE: ignored.
- sel never exceeds N_CH-1. Mask bits at or above N_CH do not exist.
- The next-enabled-index search is combinational priority logic over the latched mask above the current sel. It is evaluated within one cycle, with no extra latency.
- sel in IDLE is 0.

Decomposition:
- Shared package mux_scan_pkg holds:
  - state encoding constants ST_IDLE=0, ST_SCAN=1, ST_DONE=2;
  - N_CH=13 and SEL_W=4.
- One sub-module, mux_next_sel: combinational priority finder.
  - Inputs: mask[N_CH-1:0] and cur[SEL_W-1:0], plus a first flag for "lowest enabled index".
  - Outputs: nxt[SEL_W-1:0] and found.
  - It is used for both the first-index and next-index lookups.
- Bench instantiates the real 13:1 mux between sel and mux_out.

Test Plan:
- Full scan, dwell=0: mux data d0..d12 = 1,0,1,0,...,1, en_mask=13'h1FFF, start pulse.
  -> sel steps 0..12, one step per cycle;
  -> busy high for 13 cycles;
  -> done pulses in the following cycle;
  -> sample = 13'h1555.
- Sparse mask, dwell=2: en_mask=13'h1005.
  -> sel visits 0, 2, 12 for 3 cycles each;
  -> busy high for 9 cycles;
  -> sample = 13'h1005.
- Empty mask: en_mask=0, start.
  -> done pulses on the next cycle;
  -> busy never asserts;
  -> sample = 0.
- Continuous mode: cont=1 held, en_mask=13'h0003, dwell=0, d1 toggled between scans.
  -> done pulses every 3 cycles (2 busy plus 1 done);
  -> sample bit 1 tracks d1 per scan.
- Abort mid-scan: a prior scan left sample=13'h1555; abort is asserted while sel=5.
  -> next cycle state is IDLE, sel=0, busy=0;
  -> no done pulse;
  -> sample stays 13'h1555.
- Reset mid-scan and ignored start: rst_n=0 for one edge while sel=7.
  -> all outputs return to 0.
  -> A start asserted during SCAN has no effect on sel or the mask: a second start at sel=3 still yields the original mask's sample.
